// File: rtl/mdu_mul_ctrl.sv
// rtl/mdu_mul_ctrl.sv - MDU sequencer for the shared 33x33 pipelined multiplier
module mdu_mul_ctrl #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_dout
);

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Request opcodes
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;

  // Countdown start: the product is taken on the edge where count has reached zero
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0] state;
  logic [3:0] count;
  logic [2:0] op_q;

  logic accept;
  logic fire;
  logic is_mult_op;
  logic unused_dout_top;

  // Upper product bits are never meaningful: 33-bit extension keeps [63:0] exact
  assign unused_dout_top = ^mul_dout[65:64];

  // Handshake and completion decode; flush blocks both acceptance and the final write
  always_comb begin
    req_ready  = (state == ST_IDLE) && !flush;
    resp_valid = (state == ST_DONE);
    busy       = (state != ST_IDLE);
    accept     = req_valid && req_ready;
    fire       = (state == ST_BUSY) && (count == 4'd0) && !flush;
    is_mult_op = (req_op == OP_MULT) || (req_op == OP_MULTU) || (req_op == OP_MUL);
  end

  // State register and latency countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= 4'd0;
      op_q  <= OP_MULT;
    end else if (flush) begin
      state <= ST_IDLE;
      count <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= req_op;
            if (is_mult_op) begin
              count <= CNT_INIT;
              state <= ST_BUSY;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (count == 4'd0) begin
            state <= ST_DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= 4'd0;
        end
      endcase
    end
  end

  // Multiplier operands: captured once on accept, held steady while the pipeline runs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a <= 33'd0;
      mul_b <= 33'd0;
    end else if (accept) begin
      if (req_op == OP_MULTU) begin
        mul_a <= {1'b0, req_a};
        mul_b <= {1'b0, req_b};
      end else if ((req_op == OP_MULT) || (req_op == OP_MUL)) begin
        mul_a <= {req_a[31], req_a};
        mul_b <= {req_b[31], req_b};
      end
    end
  end

  // Architectural HI/LO: direct moves on accept, full product on MULT/MULTU completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (accept && (req_op == OP_MTHI)) begin
      hi <= req_a;
    end else if (accept && (req_op == OP_MTLO)) begin
      lo <= req_a;
    end else if (fire && ((op_q == OP_MULT) || (op_q == OP_MULTU))) begin
      hi <= mul_dout[63:32];
      lo <= mul_dout[31:0];
    end
  end

  // Response word: low product for MUL, zero for everything else, held through DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_data <= 32'd0;
    end else if (flush) begin
      resp_data <= 32'd0;
    end else if (accept && !is_mult_op) begin
      resp_data <= 32'd0;
    end else if (fire) begin
      resp_data <= (op_q == OP_MUL) ? mul_dout[31:0] : 32'd0;
    end
  end

endmodule

// File: tb/tb_mdu_mul_ctrl.sv
// tb/tb_mdu_mul_ctrl.sv - directed self-checking bench for mdu_mul_ctrl
module tb_mdu_mul_ctrl;

  localparam int L = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [32:0] mul_a;
  logic [32:0] mul_b;
  logic [65:0] mul_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic seen;

  // Clock generation
  always #5 clk = ~clk;

  // Behavioural multiplier: product of the sign-extended 33-bit operands, modulo 2^66
  assign mul_dout = {{33{mul_a[32]}}, mul_a} * {{33{mul_b[32]}}, mul_b};

  mdu_mul_ctrl #(.LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo),
    .mul_a(mul_a), .mul_b(mul_b), .mul_dout(mul_dout)
  );

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request during one cycle; returns 1 time unit after the sampling edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count edges from the accept edge (inclusive) until resp_valid is seen
  task automatic wait_resp(output int n);
    n = 1;
    while (!resp_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  // Take the response and return to IDLE
  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
    resp_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_mul_a", mul_a, 0);
    check("reset_resp_data", resp_data, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // 1: MULT -1 * 2
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    check("mult_mul_a_sext", mul_a, 66'h1_FFFF_FFFF);
    check("mult_busy", busy, 1);
    check("mult_req_ready_busy", req_ready, 0);
    wait_resp(cyc);
    check("mult_latency", cyc, L + 1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    check("mult_resp_data", resp_data, 0);
    check("mult_req_ready_done", req_ready, 0);
    take_resp();
    check("mult_idle_after", busy, 0);

    // 2: MULTU 0xFFFFFFFF * 2
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    check("multu_mul_a_zext", mul_a, 66'h0_FFFF_FFFF);
    seen = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      if (req_ready) seen = 1'b1;
      @(posedge clk);
      #1 cyc++;
    end
    check("multu_latency", cyc, L + 1);
    check("multu_req_ready_low", seen, 0);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    take_resp();

    // 3: MUL with response back-pressure
    issue(3'd2, 32'h0000_1234, 32'h0001_0000);
    wait_resp(cyc);
    check("mul_latency", cyc, L + 1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (resp_data !== 32'h1234_0000 || !resp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("mul_resp_held", seen, 0);
    check("mul_resp_data", resp_data, 32'h1234_0000);
    check("mul_hi_unchanged", hi, 32'h0000_0001);
    check("mul_lo_unchanged", lo, 32'hFFFF_FFFE);
    take_resp();
    check("mul_idle_after", busy, 0);
    check("mul_resp_valid_after", resp_valid, 0);

    // 4: MTHI then MTLO
    issue(3'd3, 32'hDEAD_BEEF, 32'h0);
    wait_resp(cyc);
    check("mthi_latency", cyc, 1);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_resp_data", resp_data, 0);
    take_resp();
    issue(3'd4, 32'hCAFE_F00D, 32'h0);
    wait_resp(cyc);
    check("mtlo_latency", cyc, 1);
    check("mtlo_lo", lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", hi, 32'hDEAD_BEEF);
    take_resp();

    // Reserved opcode: completes in one cycle, no register write
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    wait_resp(cyc);
    check("rsvd_latency", cyc, 1);
    check("rsvd_hi", hi, 32'hDEAD_BEEF);
    check("rsvd_lo", lo, 32'hCAFE_F00D);
    take_resp();

    // 5: flush on the count==0 cycle suppresses the write
    issue(3'd0, 32'd3, 32'd5);
    seen = 1'b0;
    for (int i = 0; i < L - 1; i++) begin
      if (resp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    check("flush_blocks_ready", req_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("flush_no_resp", seen, 0);
    check("flush_hi", hi, 32'hDEAD_BEEF);
    check("flush_lo", lo, 32'hCAFE_F00D);

    // Flush in IDLE with a pending MTHI: not accepted
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd3; req_a = 32'h5555_5555;
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    check("flush_idle_busy", busy, 0);
    check("flush_idle_hi", hi, 32'hDEAD_BEEF);

    // 6: asynchronous reset mid-BUSY
    issue(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_mul_a", mul_a, 0);
    check("arst_mul_b", mul_b, 0);
    @(negedge clk);
    reset = 1'b0;
    issue(3'd0, 32'd3, 32'hFFFF_FFFB);
    wait_resp(cyc);
    check("post_rst_latency", cyc, L + 1);
    check("post_rst_hi", hi, 32'hFFFF_FFFF);
    check("post_rst_lo", lo, 32'hFFFF_FFF1);
    take_resp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
